// File: rtl/pcie_os_tx_if.sv
// rtl/pcie_os_tx_if.sv - request and lane-output bundle for the ordered-set transmitter
interface pcie_os_tx_if #(
  parameter int LANE_WIDTH = 1,
  parameter int D_WIDTH    = 16,
  parameter int OS_WIDTH   = 4
);
  logic                          os_start;
  logic [OS_WIDTH-1:0]           os_type;
  logic [LANE_WIDTH-1:0]         os_lane_en;
  logic [7:0]                    link_num;
  logic [7:0]                    n_fts;
  logic [7:0]                    train_ctrl;
  logic                          skp_req;
  logic [LANE_WIDTH*D_WIDTH-1:0] tx_data;
  logic [LANE_WIDTH*2-1:0]       tx_k;
  logic [LANE_WIDTH-1:0]         tx_elec_idle;
  logic                          os_busy;
  logic                          os_sent;
  logic                          skp_done;

  modport master (
    output os_start, os_type, os_lane_en, link_num, n_fts, train_ctrl, skp_req,
    input  tx_data, tx_k, tx_elec_idle, os_busy, os_sent, skp_done
  );

  modport slave (
    input  os_start, os_type, os_lane_en, link_num, n_fts, train_ctrl, skp_req,
    output tx_data, tx_k, tx_elec_idle, os_busy, os_sent, skp_done
  );
endinterface

// File: rtl/pcie_os_tx.sv
// rtl/pcie_os_tx.sv - per-lane PCIe ordered-set transmitter, two symbols per lane per clock
module pcie_os_tx #(
  parameter int LANE_WIDTH = 1,
  parameter int D_WIDTH    = 16,
  parameter int OS_WIDTH   = 4
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  pcie_os_tx_if.slave os
);

  localparam logic [7:0] SYM_COM   = 8'hBC;
  localparam logic [7:0] SYM_PAD   = 8'hF7;
  localparam logic [7:0] SYM_EIDL  = 8'h7C;
  localparam logic [7:0] SYM_FTS   = 8'h3C;
  localparam logic [7:0] SYM_SKP   = 8'h1C;
  localparam logic [7:0] SYM_D10_2 = 8'h4A;
  localparam logic [7:0] SYM_D5_2  = 8'h45;

  localparam logic [OS_WIDTH-1:0] OS_T1_LL = OS_WIDTH'(0);
  localparam logic [OS_WIDTH-1:0] OS_T2_LL = OS_WIDTH'(1);
  localparam logic [OS_WIDTH-1:0] OS_T1    = OS_WIDTH'(3);
  localparam logic [OS_WIDTH-1:0] OS_T2    = OS_WIDTH'(4);
  localparam logic [OS_WIDTH-1:0] OS_IDLE  = OS_WIDTH'(5);
  localparam logic [OS_WIDTH-1:0] OS_EIDLE = OS_WIDTH'(6);
  localparam logic [OS_WIDTH-1:0] OS_NFTS  = OS_WIDTH'(7);

  typedef enum logic [2:0] {ST_EI, ST_TS, ST_IDL, ST_EIOS, ST_FTS, ST_SKP} state_t;

  // current set on the wire (state/cnt describe the registered output cycle)
  state_t                state, resume;
  logic [2:0]            cnt;
  logic                  ts2, lip;
  logic [LANE_WIDTH-1:0] mask;
  logic [7:0]            fts_left;
  logic [7:0]            link_q, nfts_q, tctl_q;
  logic                  pend_v;
  logic [OS_WIDTH-1:0]   pend_type;
  logic [LANE_WIDTH-1:0] pend_mask;
  logic                  skp_pend;

  state_t                nxt_state, nxt_resume, cont;
  logic [2:0]            nxt_cnt;
  logic                  nxt_ts2, nxt_lip;
  logic [LANE_WIDTH-1:0] nxt_mask;
  logic [7:0]            nxt_fts, cont_fts;
  logic                  nxt_pend_v;
  logic [OS_WIDTH-1:0]   nxt_pend_type;
  logic [LANE_WIDTH-1:0] nxt_pend_mask;
  logic                  nxt_skp;
  logic                  req_ok, last, use_req, ts_start;
  logic [OS_WIDTH-1:0]   r_type;
  logic [LANE_WIDTH-1:0] r_mask;
  logic [7:0]            f_link, f_nfts, f_tctl;

  logic [LANE_WIDTH*D_WIDTH-1:0] data_n;
  logic [LANE_WIDTH*2-1:0]       k_n;
  logic [LANE_WIDTH-1:0]         ei_n;
  logic [8:0]                    sym_lo, sym_hi;

  // one symbol of the current set as {K, byte}
  function automatic logic [8:0] sym_of(input state_t st, input logic [3:0] idx,
                                        input logic [7:0] lane, input logic t2, input logic lp,
                                        input logic [7:0] lk, input logic [7:0] nf,
                                        input logic [7:0] tc);
    logic [8:0] s;
    s = 9'h000;
    case (st)
      ST_TS: begin
        case (idx)
          4'd0:    s = {1'b1, SYM_COM};
          4'd1:    s = lp ? {1'b1, SYM_PAD} : {1'b0, lk};
          4'd2:    s = lp ? {1'b1, SYM_PAD} : {1'b0, lane};
          4'd3:    s = {1'b0, nf};
          4'd4:    s = {1'b0, 8'h02};
          4'd5:    s = {1'b0, tc};
          default: s = {1'b0, t2 ? SYM_D5_2 : SYM_D10_2};
        endcase
      end
      ST_EIOS: s = (idx == 4'd0) ? {1'b1, SYM_COM} : {1'b1, SYM_EIDL};
      ST_FTS:  s = (idx == 4'd0) ? {1'b1, SYM_COM} : {1'b1, SYM_FTS};
      ST_SKP:  s = (idx == 4'd0) ? {1'b1, SYM_COM} : {1'b1, SYM_SKP};
      default: s = 9'h000;
    endcase
    return s;
  endfunction

  // choose the set for the next output cycle; requests and SKP only act at set boundaries
  always_comb begin
    nxt_state     = state;
    nxt_cnt       = cnt + 3'd1;
    nxt_resume    = resume;
    nxt_ts2       = ts2;
    nxt_lip       = lip;
    nxt_mask      = mask;
    nxt_fts       = fts_left;
    nxt_pend_v    = pend_v;
    nxt_pend_type = pend_type;
    nxt_pend_mask = pend_mask;
    nxt_skp       = skp_pend | os.skp_req;
    cont          = ST_EI;
    cont_fts      = fts_left;
    use_req       = 1'b0;
    r_type        = pend_type;
    r_mask        = pend_mask;

    req_ok = os.os_start && (os.os_type inside {OS_T1_LL, OS_T2_LL, OS_T1, OS_T2,
                                                 OS_IDLE, OS_EIDLE, OS_NFTS});
    last   = (state == ST_EI) || (state == ST_IDL) ||
             ((state == ST_TS) && (cnt == 3'd7)) ||
             ((state inside {ST_EIOS, ST_FTS, ST_SKP}) && (cnt == 3'd1));

    if (req_ok) begin
      nxt_pend_v    = 1'b1;
      nxt_pend_type = os.os_type;
      nxt_pend_mask = os.os_lane_en;
    end

    if (last) begin
      nxt_cnt = 3'd0;
      // what the stream does next if nothing new is requested
      case (state)
        ST_TS:   cont = ST_TS;
        ST_IDL:  cont = ST_IDL;
        ST_FTS: begin
          if (fts_left > 8'd1) begin
            cont     = ST_FTS;
            cont_fts = fts_left - 8'd1;
          end else begin
            cont = ST_IDL;
          end
        end
        ST_SKP:  cont = resume;
        default: cont = ST_EI;
      endcase

      if ((state inside {ST_TS, ST_IDL, ST_FTS}) && (skp_pend || os.skp_req)) begin
        // SKP wins; any request stays pending for the boundary after it
        nxt_state  = ST_SKP;
        nxt_resume = cont;
        nxt_fts    = cont_fts;
        nxt_skp    = 1'b0;
      end else begin
        use_req    = req_ok || pend_v;
        r_type     = req_ok ? os.os_type : pend_type;
        r_mask     = req_ok ? os.os_lane_en : pend_mask;
        nxt_pend_v = 1'b0;
        if (use_req) begin
          nxt_mask = r_mask;
          case (r_type)
            OS_T1_LL, OS_T2_LL, OS_T1, OS_T2: begin
              nxt_state = ST_TS;
              nxt_ts2   = (r_type == OS_T2_LL) || (r_type == OS_T2);
              nxt_lip   = (r_type == OS_T1_LL) || (r_type == OS_T2_LL);
            end
            OS_IDLE:  nxt_state = ST_IDL;
            OS_EIDLE: nxt_state = ST_EIOS;
            OS_NFTS: begin
              if (os.n_fts == 8'd0) begin
                nxt_state = ST_IDL;
              end else begin
                nxt_state = ST_FTS;
                nxt_fts   = os.n_fts;
              end
            end
            default: begin
              nxt_state = cont;
              nxt_fts   = cont_fts;
            end
          endcase
        end else begin
          nxt_state = cont;
          nxt_fts   = cont_fts;
        end
      end
    end

    ts_start = last && (nxt_state == ST_TS);
    f_link   = ts_start ? os.link_num   : link_q;
    f_nfts   = ts_start ? os.n_fts      : nfts_q;
    f_tctl   = ts_start ? os.train_ctrl : tctl_q;
  end

  // per-lane symbols for the next output cycle; disabled lanes and EI stay quiet
  always_comb begin
    data_n = '0;
    k_n    = '0;
    ei_n   = '1;
    sym_lo = 9'h000;
    sym_hi = 9'h000;
    for (int l = 0; l < LANE_WIDTH; l++) begin
      if (nxt_mask[l] && (nxt_state != ST_EI)) begin
        sym_lo = sym_of(nxt_state, {nxt_cnt, 1'b0}, 8'(l), nxt_ts2, nxt_lip, f_link, f_nfts, f_tctl);
        sym_hi = sym_of(nxt_state, {nxt_cnt, 1'b1}, 8'(l), nxt_ts2, nxt_lip, f_link, f_nfts, f_tctl);
        data_n[D_WIDTH*l +: D_WIDTH] = {sym_hi[7:0], sym_lo[7:0]};
        k_n[2*l +: 2]                = {sym_hi[8], sym_lo[8]};
        ei_n[l]                      = 1'b0;
      end
    end
  end

  // state, pending requests, captured TS fields and registered outputs
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_EI;
      resume          <= ST_EI;
      cnt             <= 3'd0;
      ts2             <= 1'b0;
      lip             <= 1'b0;
      mask            <= '0;
      fts_left        <= 8'd0;
      link_q          <= 8'd0;
      nfts_q          <= 8'd0;
      tctl_q          <= 8'd0;
      pend_v          <= 1'b0;
      pend_type       <= '0;
      pend_mask       <= '0;
      skp_pend        <= 1'b0;
      os.tx_data      <= '0;
      os.tx_k         <= '0;
      os.tx_elec_idle <= '1;
      os.os_busy      <= 1'b0;
      os.os_sent      <= 1'b0;
      os.skp_done     <= 1'b0;
    end else begin
      state           <= nxt_state;
      resume          <= nxt_resume;
      cnt             <= nxt_cnt;
      ts2             <= nxt_ts2;
      lip             <= nxt_lip;
      mask            <= nxt_mask;
      fts_left        <= nxt_fts;
      pend_v          <= nxt_pend_v;
      pend_type       <= nxt_pend_type;
      pend_mask       <= nxt_pend_mask;
      skp_pend        <= nxt_skp;
      if (ts_start) begin
        link_q <= os.link_num;
        nfts_q <= os.n_fts;
        tctl_q <= os.train_ctrl;
      end
      os.tx_data      <= data_n;
      os.tx_k         <= k_n;
      os.tx_elec_idle <= ei_n;
      os.os_busy      <= (nxt_state != ST_EI);
      os.os_sent      <= ((nxt_state == ST_TS) && (nxt_cnt == 3'd7)) ||
                         ((nxt_state inside {ST_EIOS, ST_FTS}) && (nxt_cnt == 3'd1));
      os.skp_done     <= (nxt_state == ST_SKP) && (nxt_cnt == 3'd1);
    end
  end

endmodule

// File: tb/tb_pcie_os_tx.sv
// tb/tb_pcie_os_tx.sv - scoreboard bench for pcie_os_tx against a set-level reference model
module tb_pcie_os_tx;

  localparam int LW = 4;
  localparam int K_EI = 0, K_TS = 1, K_IDL = 2, K_EIOS = 3, K_FTS = 4, K_SKP = 5;

  typedef struct {
    logic [LW*16-1:0] d;
    logic [LW*2-1:0]  k;
    logic [LW-1:0]    ei;
    logic             busy;
    logic             sent;
    logic             skpd;
  } beat_t;

  logic clk;
  logic rst_n;
  pcie_os_tx_if #(.LANE_WIDTH(LW)) bus();

  pcie_os_tx #(.LANE_WIDTH(LW)) dut (
    .sys_clk(clk),
    .rst_n  (rst_n),
    .os     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit mon_en   = 0;

  beat_t exp_q[$];
  beat_t set_q[$];

  // reference model state: the set being sent, what follows it, and pending work
  int               m_kind, m_resume, m_fts_left;
  bit               m_ts2, m_lip, pend_v, skp_flag;
  logic [LW-1:0]    m_mask, pend_mask;
  logic [3:0]       pend_type;
  logic [7:0]       f_link, f_nf, f_tc;
  logic [7:0]       drv_lk, drv_nf, drv_tc;

  function automatic bit valid_type(input logic [3:0] t);
    return t inside {4'd0, 4'd1, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7};
  endfunction

  // expand a whole ordered set into its per-cycle beats
  task automatic start_set(input int kind);
    beat_t      bt [8];
    logic [8:0] sq[$];
    int         nb;
    m_kind = kind;
    if (kind == K_TS) begin
      f_link = bus.link_num;
      f_nf   = bus.n_fts;
      f_tc   = bus.train_ctrl;
    end
    nb = (kind == K_TS) ? 8 : ((kind == K_EI || kind == K_IDL) ? 1 : 2);
    for (int c = 0; c < 8; c++) bt[c] = '{default: '0};
    for (int l = 0; l < LW; l++) begin
      sq.delete();
      case (kind)
        K_TS: begin
          sq.push_back({1'b1, 8'hBC});
          sq.push_back(m_lip ? {1'b1, 8'hF7} : {1'b0, f_link});
          sq.push_back(m_lip ? {1'b1, 8'hF7} : {1'b0, 8'(l)});
          sq.push_back({1'b0, f_nf});
          sq.push_back({1'b0, 8'h02});
          sq.push_back({1'b0, f_tc});
          repeat (10) sq.push_back({1'b0, m_ts2 ? 8'h45 : 8'h4A});
        end
        K_EIOS: begin sq.push_back({1'b1, 8'hBC}); repeat (3) sq.push_back({1'b1, 8'h7C}); end
        K_FTS:  begin sq.push_back({1'b1, 8'hBC}); repeat (3) sq.push_back({1'b1, 8'h3C}); end
        K_SKP:  begin sq.push_back({1'b1, 8'hBC}); repeat (3) sq.push_back({1'b1, 8'h1C}); end
        default: repeat (2) sq.push_back(9'h000);
      endcase
      for (int c = 0; c < nb; c++) begin
        if (m_mask[l] && kind != K_EI) begin
          bt[c].d[16*l +: 16] = {sq[2*c+1][7:0], sq[2*c][7:0]};
          bt[c].k[2*l +: 2]   = {sq[2*c+1][8], sq[2*c][8]};
        end else begin
          bt[c].ei[l] = 1'b1;
        end
      end
    end
    for (int c = 0; c < nb; c++) begin
      bt[c].busy = (kind != K_EI);
      bt[c].sent = (c == nb - 1) && (kind == K_TS || kind == K_EIOS || kind == K_FTS);
      bt[c].skpd = (c == nb - 1) && (kind == K_SKP);
      set_q.push_back(bt[c]);
    end
  endtask

  task automatic apply_req(input logic [3:0] t, input logic [LW-1:0] m);
    m_mask = m;
    if (t <= 4'd4) begin
      m_ts2 = (t == 4'd1 || t == 4'd4);
      m_lip = (t <= 4'd1);
      start_set(K_TS);
    end else if (t == 4'd5) start_set(K_IDL);
    else if (t == 4'd6) start_set(K_EIOS);
    else if (bus.n_fts == 8'd0) start_set(K_IDL);
    else begin
      m_fts_left = int'(bus.n_fts);
      start_set(K_FTS);
    end
  endtask

  task automatic model_reset();
    set_q.delete();
    m_mask = '0; m_ts2 = 0; m_lip = 0; m_fts_left = 0; m_resume = K_EI;
    pend_v = 0; pend_type = '0; pend_mask = '0; skp_flag = 0;
    start_set(K_EI);
  endtask

  // advance one cycle using the inputs just driven; queue the beat the DUT must show next
  task automatic model_step();
    bit    req_now;
    int    cont;
    beat_t gone;
    req_now = bus.os_start && valid_type(bus.os_type);
    gone = set_q.pop_front();
    if (set_q.size() != 0) begin
      if (req_now) begin pend_v = 1; pend_type = bus.os_type; pend_mask = bus.os_lane_en; end
      if (bus.skp_req) skp_flag = 1;
    end else begin
      case (m_kind)
        K_TS:   cont = K_TS;
        K_IDL:  cont = K_IDL;
        K_FTS:  if (m_fts_left > 1) begin m_fts_left--; cont = K_FTS; end else cont = K_IDL;
        K_SKP:  cont = m_resume;
        default: cont = K_EI;
      endcase
      if ((m_kind == K_TS || m_kind == K_IDL || m_kind == K_FTS) && (skp_flag || bus.skp_req)) begin
        if (req_now) begin pend_v = 1; pend_type = bus.os_type; pend_mask = bus.os_lane_en; end
        skp_flag = 0;
        m_resume = cont;
        start_set(K_SKP);
      end else begin
        if (bus.skp_req) skp_flag = 1;
        if (req_now) begin apply_req(bus.os_type, bus.os_lane_en); pend_v = 0; end
        else if (pend_v) begin apply_req(pend_type, pend_mask); pend_v = 0; end
        else start_set(cont);
      end
    end
    exp_q.push_back(set_q[0]);
  endtask

  task automatic drive(input bit st, input logic [3:0] ty, input logic [LW-1:0] m, input bit sk);
    @(negedge clk);
    bus.os_start   = st;
    bus.os_type    = ty;
    bus.os_lane_en = m;
    bus.skp_req    = sk;
    bus.link_num   = drv_lk;
    bus.n_fts      = drv_nf;
    bus.train_ctrl = drv_tc;
    model_step();
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 4'd0, '0, 0);
  endtask

  task automatic check_reset_vals(input string tag);
    n_checks++;
    if (bus.tx_data !== '0 || bus.tx_k !== '0 || bus.tx_elec_idle !== '1 ||
        bus.os_busy !== 1'b0 || bus.os_sent !== 1'b0 || bus.skp_done !== 1'b0)
      $display("FAIL %s got d=%h k=%h ei=%b busy=%b sent=%b skp=%b want d=0 k=0 ei=1111 busy=0 sent=0 skp=0",
               tag, bus.tx_data, bus.tx_k, bus.tx_elec_idle, bus.os_busy, bus.os_sent, bus.skp_done);
    else n_pass++;
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    mon_en = 0;
    rst_n  = 1'b0;
    #1;
    check_reset_vals(tag);
    exp_q.delete();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    bus.os_start = 0; bus.skp_req = 0;
    model_step();
    mon_en = 1;
  endtask

  // monitor: compare every output cycle against the scoreboard
  initial begin
    beat_t e;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (bus.tx_data !== e.d || bus.tx_k !== e.k || bus.tx_elec_idle !== e.ei ||
            bus.os_busy !== e.busy || bus.os_sent !== e.sent || bus.skp_done !== e.skpd)
          $display("FAIL beat t=%0t got d=%h k=%h ei=%b busy=%b sent=%b skp=%b want d=%h k=%h ei=%b busy=%b sent=%b skp=%b",
                   $time, bus.tx_data, bus.tx_k, bus.tx_elec_idle, bus.os_busy, bus.os_sent, bus.skp_done,
                   e.d, e.k, e.ei, e.busy, e.sent, e.skpd);
        else n_pass++;
      end
    end
  end

  initial begin
    logic [3:0] ty;
    rst_n = 1'b0;
    bus.os_start = 0; bus.os_type = '0; bus.os_lane_en = '0; bus.skp_req = 0;
    bus.link_num = '0; bus.n_fts = '0; bus.train_ctrl = '0;
    drv_lk = 8'h05; drv_nf = 8'h20; drv_tc = 8'h00;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_reset_vals("reset_state");
    rst_n = 1'b1;
    model_step();
    mon_en = 1;

    // TS1 on lane 0, then TS2 requested mid-set
    drive(1, 4'd3, 4'b0001, 0); idle(18);
    drive(1, 4'd4, 4'b0001, 0); idle(12);
    // idle stream with SKP insertion
    drive(1, 4'd5, 4'b0001, 0); idle(3); drive(0, 4'd0, '0, 1); idle(4);
    // EIOS then a held SKP request in EI
    drive(1, 4'd6, 4'b0001, 0); idle(4); drive(0, 4'd0, '0, 1); idle(3);
    // TS1 LIP/LAP on lanes 0 and 2; held SKP follows the first set
    drive(1, 4'd0, 4'b0101, 0); idle(20);
    // FTS x3, then FTS with count zero, then an ignored code
    drv_nf = 8'd3; drive(1, 4'd7, 4'b1111, 0); idle(9);
    drv_nf = 8'd0; drive(1, 4'd7, 4'b1111, 0); idle(3);
    drive(1, 4'd2, 4'b1111, 0); idle(3);
    // last of several starts wins; SKP and start at the same boundary
    drv_nf = 8'h11; drive(1, 4'd3, 4'b1111, 0); idle(2);
    drive(1, 4'd6, 4'b1111, 0); drive(1, 4'd1, 4'b0011, 1); idle(22);
    // reset in the middle of a TS2
    drive(1, 4'd4, 4'b1111, 0); idle(3);
    do_reset("reset_midset");
    idle(2);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      drv_lk = 8'($urandom);
      drv_tc = 8'($urandom);
      drv_nf = 8'($urandom_range(0, 3));
      if ($urandom_range(0, 4) == 0) ty = 4'($urandom_range(0, 15));
      else begin
        ty = 4'($urandom_range(0, 6));
        if (ty == 4'd2) ty = 4'd7;
      end
      drive($urandom_range(0, 9) == 0, ty, LW'($urandom), $urandom_range(0, 24) == 0);
    end

    @(posedge clk);
    #2;
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL drain got %0d queued beats want 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
